// File: rtl/signed_div_seq.sv
// -----------------------------------------------------------------------------
// signed_div_seq
//
// Sequential signed divider: 8-bit dividend / 4-bit divisor. It undoes the
// team's 4x4 signed multiplier. The quotient truncates toward zero, and the
// remainder takes the sign of the dividend, so that
//   dividend = quotient*divisor + remainder.
//
// The core is restoring division on magnitudes, one quotient bit per clock
// over 8 CALC cycles. A single FIX cycle then applies the signs and loads the
// outputs.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   start      request, sampled only while idle
//   dividend   signed 8-bit operand, captured with start
//   divisor    signed 4-bit operand, captured with start
//   busy       high during the CALC/FIX cycles
//   done       one-cycle pulse, quotient/remainder valid
//   quotient   signed 8-bit result, held until the next FIX or reset
//   remainder  signed 4-bit result, held until the next FIX or reset
//   dz         divide-by-zero flag (only with DIV_ZERO_DETECT_EN)
//
// Optional feature macro: DIV_ZERO_DETECT_EN
//   Defined:   a zero divisor skips CALC. The block returns 0/0 with dz=1 in
//              the done cycle.
//   Undefined: there is no dz port. A zero divisor runs the normal 9-cycle
//              path and returns quotient 8'hFF, remainder dividend[3:0].
// -----------------------------------------------------------------------------
module signed_div_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [7:0] quotient,
  output logic [3:0] remainder
`ifdef DIV_ZERO_DETECT_EN
  ,
  output logic       dz
`endif
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t     state;
  state_t     state_next;
  logic [2:0] cnt;
  logic [7:0] q_mag;
  logic [3:0] rem_mag;
  logic [3:0] dvs_mag;
  logic       neg_q;
  logic       neg_r;
  logic       dvs_zero;
  logic [4:0] trial;
  logic [3:0] diff;
  logic       take;
`ifndef DIV_ZERO_DETECT_EN
  logic [3:0] dvd_low;
`endif

  // State register. Reset always returns to IDLE, so an operation that is in
  // flight when reset arrives is simply dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and busy. A start request is only honoured in IDLE.
  // The done cycle is already IDLE, which is what makes back-to-back starts
  // possible.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef DIV_ZERO_DETECT_EN
          state_next = (divisor == 4'd0) ? FIX : CALC;
`else
          state_next = CALC;
`endif
        end
      end
      CALC: begin
        busy = 1'b1;
        if (cnt == 3'd7) begin
          state_next = FIX;
        end
      end
      FIX: begin
        busy       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // One restoring step. The partial remainder always stays below the divisor
  // magnitude (at most 8), so 4 bits are enough. The subtraction is done
  // modulo 16, which is exact whenever the trial value is at least the
  // divisor.
  always_comb begin
    trial = {rem_mag, q_mag[7]};
    take  = (trial >= {1'b0, dvs_mag});
    diff  = trial[3:0] - dvs_mag;
  end

  // Datapath.
  // IDLE captures the operand magnitudes and signs. CALC shifts one
  // quotient bit in per cycle, replacing dividend bits in q_mag. FIX applies
  // the signs, loads the outputs and raises done.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= 3'd0;
      q_mag     <= 8'd0;
      rem_mag   <= 4'd0;
      dvs_mag   <= 4'd0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      dvs_zero  <= 1'b0;
      done      <= 1'b0;
      quotient  <= 8'd0;
      remainder <= 4'd0;
`ifdef DIV_ZERO_DETECT_EN
      dz        <= 1'b0;
`else
      dvd_low   <= 4'd0;
`endif
    end else begin
      done <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
      dz   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            q_mag    <= dividend[7] ? -dividend : dividend;
            dvs_mag  <= divisor[3] ? -divisor : divisor;
            neg_q    <= dividend[7] ^ divisor[3];
            neg_r    <= dividend[7];
            dvs_zero <= (divisor == 4'd0);
            rem_mag  <= 4'd0;
            cnt      <= 3'd0;
`ifndef DIV_ZERO_DETECT_EN
            dvd_low  <= dividend[3:0];
`endif
          end
        end
        CALC: begin
          q_mag   <= {q_mag[6:0], take};
          rem_mag <= take ? diff : trial[3:0];
          cnt     <= cnt + 3'd1;
        end
        FIX: begin
          done <= 1'b1;
          cnt  <= 3'd0;
          if (dvs_zero) begin
`ifdef DIV_ZERO_DETECT_EN
            quotient  <= 8'd0;
            remainder <= 4'd0;
            dz        <= 1'b1;
`else
            quotient  <= 8'hFF;
            remainder <= dvd_low;
`endif
          end else begin
            quotient  <= neg_q ? -q_mag : q_mag;
            remainder <= neg_r ? -rem_mag : rem_mag;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_div_seq.sv
// -----------------------------------------------------------------------------
// tb_signed_div_seq
//
// Directed test of signed_div_seq. A table of {dividend, divisor, quotient,
// remainder} records is applied in a loop. Hand-written sequences follow for
// back-to-back starts, a start while busy, reset mid-operation, and a zero
// divisor. Define DIV_ZERO_DETECT_EN to test the dz build.
// -----------------------------------------------------------------------------
module tb_signed_div_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
`ifdef DIV_ZERO_DETECT_EN
  logic       dz;
`endif

  int compared;
  int mismatched;

  typedef struct {
    logic [7:0] dvd;
    logic [3:0] dvs;
    logic [7:0] q;
    logic [3:0] r;
  } vec_t;

  vec_t vecs[8];

  signed_div_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
`ifdef DIV_ZERO_DETECT_EN
    ,
    .dz        (dz)
`endif
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one value against its expected value and count the result.
  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Call 1 ns after an edge. Raises start for one edge, then scrambles the
  // operand inputs. Returns with the time just past the start edge.
  task automatic applyStimulus(input logic [7:0] dvd, input logic [3:0] dvs);
    start    = 1'b1;
    dividend = dvd;
    divisor  = dvs;
    tick();
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
  endtask

  // Wait (bounded) for done, then check latency, results and busy.
  task automatic waitDone(input string name, input int exp_lat,
                          input logic [7:0] exp_q, input logic [3:0] exp_r);
    int lat;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      if (lat == 0) begin
        tick();
        if (done) lat = k;
      end
    end
    checkOutput({name, " latency"}, lat, exp_lat);
    checkOutput({name, " quotient"}, int'(quotient), int'(exp_q));
    checkOutput({name, " remainder"}, int'(remainder), int'(exp_r));
    checkOutput({name, " busy in done cycle"}, int'(busy), 0);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    start      = 1'b0;
    dividend   = 8'd0;
    divisor    = 4'd0;

    vecs[0] = '{8'd100,  4'd7,   8'h0E, 4'h2};
    vecs[1] = '{8'h9C,   4'd7,   8'hF2, 4'hE};
    vecs[2] = '{8'h80,   4'hF,   8'h80, 4'h0};
    vecs[3] = '{8'd5,    4'd7,   8'h00, 4'h5};
    vecs[4] = '{8'hF9,   4'd2,   8'hFD, 4'hF};
    vecs[5] = '{8'd127,  4'h8,   8'hF1, 4'h7};
    vecs[6] = '{8'h80,   4'd7,   8'hEE, 4'hE};
    vecs[7] = '{8'hFF,   4'd7,   8'h00, 4'hF};

    tick();
    tick();
    rst = 1'b1;
    start = 1'b1;
    tick();
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset done", int'(done), 0);
    checkOutput("reset quotient", int'(quotient), 0);
    checkOutput("reset remainder", int'(remainder), 0);
    rst   = 1'b0;
    start = 1'b0;
    tick();
    checkOutput("idle busy", int'(busy), 0);

    // Table-driven vectors, each with a 9-cycle latency check.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].dvd, vecs[i].dvs);
      checkOutput($sformatf("vec%0d busy", i), int'(busy), 1);
      waitDone($sformatf("vec%0d", i), 9, vecs[i].q, vecs[i].r);
`ifdef DIV_ZERO_DETECT_EN
      checkOutput($sformatf("vec%0d dz", i), int'(dz), 0);
`endif
      tick();
      checkOutput($sformatf("vec%0d done pulse width", i), int'(done), 0);
    end

    // Back-to-back: the second start is issued in the done cycle of the first.
    applyStimulus(8'h9C, 4'd7);
    waitDone("b2b first", 9, 8'hF2, 4'hE);
    applyStimulus(8'd100, 4'h8);
    checkOutput("b2b second accepted busy", int'(busy), 1);
    waitDone("b2b second", 9, 8'hF4, 4'h4);
    tick();

    // A start pulse with new operands during cycle 4 is ignored.
    applyStimulus(8'd100, 4'd7);
    tick();
    tick();
    tick();
    start    = 1'b1;
    dividend = 8'd50;
    divisor  = 4'd3;
    tick();
    start    = 1'b0;
    waitDone("ignored start", 5, 8'h0E, 4'h2);
    tick();

    // Reset at cycle 5 drops the operation, with no done afterwards.
    applyStimulus(8'd100, 4'd7);
    tick();
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("mid rst busy", int'(busy), 0);
    checkOutput("mid rst done", int'(done), 0);
    checkOutput("mid rst quotient", int'(quotient), 0);
    checkOutput("mid rst remainder", int'(remainder), 0);
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 10; k++) begin
        tick();
        if (done) seen++;
      end
      checkOutput("mid rst no done", seen, 0);
    end
    checkOutput("mid rst quotient held", int'(quotient), 0);
    applyStimulus(8'd50, 4'd3);
    waitDone("after rst 50/3", 9, 8'h10, 4'h2);
    tick();

    // Zero divisor.
    applyStimulus(8'h9A, 4'd0);
`ifdef DIV_ZERO_DETECT_EN
    waitDone("div zero", 1, 8'h00, 4'h0);
    checkOutput("div zero dz", int'(dz), 1);
    tick();
    checkOutput("div zero dz cleared", int'(dz), 0);
`else
    waitDone("div zero", 9, 8'hFF, 4'hA);
    tick();
`endif
    checkOutput("result held after done", int'(remainder),
`ifdef DIV_ZERO_DETECT_EN
                0
`else
                32'hA
`endif
               );

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
